// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the Gray receive monitor.
// Helpers work on a 32-bit container; callers zero-extend and truncate.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int GMAX = 32;
  localparam logic [GMAX-1:0] GONE = 32'd1;

  function automatic logic [GMAX-1:0] gray2bin(input logic [GMAX-1:0] g);
    logic [GMAX-1:0] b;
    b[GMAX-1] = g[GMAX-1];
    for (int i = GMAX - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic one_bit_diff(input logic [GMAX-1:0] a, input logic [GMAX-1:0] b);
    logic [GMAX-1:0] x;
    x = a ^ b;
    return (x != '0) && ((x & (x - GONE)) == '0);
  endfunction

endpackage

// File: rtl/gray_rx_mon_sync.sv
// Plain flop chain bringing the Gray word into the local clock domain.
module gray_sync
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gray_rx_mon.sv
// Gray receive monitor: synchronise, convert to binary, police forward steps,
// track lock and a saturating error count with a FAULT latch.
module gray_rx_mon
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_STEPS  = 4,
  parameter int ERR_LIMIT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             inc_pulse,
  output logic             wrap_pulse,
  output logic             step_err,
  output logic             locked,
  output logic             fault,
  output logic [7:0]       err_count
);

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FILL = FW'(SYNC_STAGES);

  state_t           state;
  logic [WIDTH-1:0] gs, prev;
  logic [FW-1:0]    fill_cnt;
  logic [7:0]       lock_cnt;

  logic [WIDTH-1:0] gs_bin, prev_bin, prev_inc;
  logic             hold, fwd, illegal, hits_limit;
  logic [7:0]       err_inc;

  gray_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gray_in),
    .q   (gs)
  );

  always_comb begin
    gs_bin     = WIDTH'(gray2bin(GMAX'(gs)));
    prev_bin   = WIDTH'(gray2bin(GMAX'(prev)));
    prev_inc   = prev_bin + WIDTH'(1);
    hold       = (gs == prev);
    fwd        = one_bit_diff(GMAX'(gs), GMAX'(prev)) && (gs_bin == prev_inc);
    illegal    = !hold && !fwd;
    err_inc    = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
    hits_limit = (err_inc == 8'(ERR_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      fill_cnt   <= FILL;
      prev       <= '0;
      lock_cnt   <= '0;
      err_count  <= '0;
      bin_out    <= '0;
      inc_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      inc_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
      if (clr_err) err_count <= '0;
      case (state)
        ST_IDLE: begin
          if (fill_cnt != '0) begin
            fill_cnt <= fill_cnt - FW'(1);
          end else begin
            prev     <= gs;
            lock_cnt <= '0;
            state    <= ST_ACQ;
          end
        end
        ST_ACQ, ST_LOCK: begin
          bin_out    <= gs_bin;
          inc_pulse  <= fwd;
          wrap_pulse <= fwd && (prev_bin == '1);
          step_err   <= illegal;
          if (!hold) prev <= gs;
          // A coincident clear wins over the increment and blocks FAULT entry.
          if (illegal && !clr_err) err_count <= err_inc;
          if (illegal && !clr_err && hits_limit) begin
            state    <= ST_FAULT;
            lock_cnt <= '0;
            locked   <= 1'b0;
            fault    <= 1'b1;
          end else if (illegal) begin
            state    <= ST_ACQ;
            lock_cnt <= '0;
            locked   <= 1'b0;
          end else if (fwd && state == ST_ACQ) begin
            lock_cnt <= lock_cnt + 8'd1;
            if (lock_cnt + 8'd1 == 8'(LOCK_STEPS)) begin
              state  <= ST_LOCK;
              locked <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          if (clr_err) begin
            state    <= ST_IDLE;
            fill_cnt <= FILL;
            fault    <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_rx_mon.sv
// Self-checking bench for gray_rx_mon: directed scenarios plus random stimulus
// against a table-driven behavioural model of the monitor.
module tb_gray_rx_mon;

  localparam int W    = 4;
  localparam int SS   = 2;
  localparam int LS   = 4;
  localparam int EL   = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] gray_in = 4'h5;
  logic         clr_err = 1'b0;
  logic [W-1:0] bin_out;
  logic         inc_pulse, wrap_pulse, step_err, locked, fault;
  logic [7:0]   err_count;

  gray_rx_mon #(.WIDTH(W), .SYNC_STAGES(SS), .LOCK_STEPS(LS), .ERR_LIMIT(EL)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .clr_err    (clr_err),
    .bin_out    (bin_out),
    .inc_pulse  (inc_pulse),
    .wrap_pulse (wrap_pulse),
    .step_err   (step_err),
    .locked     (locked),
    .fault      (fault),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 acquiring, 2 locked, 3 fault
  int         inv_tab [16];
  logic [3:0] pipe [SS];
  logic [3:0] last;
  int m_mode, idle_age, steps, e_errs, e_bin;
  bit e_inc, e_wrap, e_step;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b % 16);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; idle_age = 0; steps = 0; e_errs = 0; e_bin = 0;
    e_inc = 0; e_wrap = 0; e_step = 0; last = '0;
    for (int i = 0; i < SS; i++) pipe[i] = '0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] gin, input logic c);
    logic [3:0] gsv;
    if (r) begin
      model_reset();
      return;
    end
    gsv = pipe[SS-1];
    for (int i = SS - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = gin;
    e_inc = 0; e_wrap = 0; e_step = 0;
    if (m_mode == 3) begin
      if (c) begin e_errs = 0; m_mode = 0; idle_age = 0; end
    end else begin
      if (c) e_errs = 0;
      if (m_mode == 0) begin
        if (idle_age == SS) begin last = gsv; steps = 0; m_mode = 1; end
        else idle_age++;
      end else begin
        e_bin = inv_tab[gsv];
        if (gsv != last) begin
          if (inv_tab[gsv] == (inv_tab[last] + 1) % 16) begin
            e_inc  = 1;
            e_wrap = (inv_tab[last] == 15);
            if (m_mode == 1) begin
              steps++;
              if (steps >= LS) m_mode = 2;
            end
          end else begin
            e_step = 1;
            steps  = 0;
            m_mode = 1;
            if (!c) begin
              if (e_errs < 255) e_errs++;
              if (e_errs == EL) m_mode = 3;
            end
          end
          last = gsv;
        end
      end
    end
  endtask

  task automatic compare();
    chk("bin_out",    32'(bin_out),    32'(e_bin));
    chk("inc_pulse",  32'(inc_pulse),  32'(e_inc));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(e_wrap));
    chk("step_err",   32'(step_err),   32'(e_step));
    chk("locked",     32'(locked),     32'(m_mode == 2));
    chk("fault",      32'(fault),      32'(m_mode == 3));
    chk("err_count",  32'(err_count),  32'(e_errs));
  endtask

  task automatic cycle(input logic r, input logic [3:0] g, input logic c);
    @(negedge clk);
    rst = r; gray_in = g; clr_err = c;
    @(posedge clk);
    model_step(r, g, c);
    #1;
    compare();
  endtask

  int cur_b;
  int n_wrap, n_inc, n_err;

  task automatic walk(input int n);
    for (int i = 0; i < n; i++) begin
      cur_b = (cur_b + 1) % 16;
      cycle(1'b0, to_gray(cur_b), 1'b0);
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, to_gray(cur_b), 1'b0);
  endtask

  task automatic jump2();
    cur_b = (cur_b + 2) % 16;
    cycle(1'b0, to_gray(cur_b), 1'b0);
  endtask

  initial begin
    for (int b = 0; b < 16; b++) inv_tab[to_gray(b)] = b;
    model_reset();

    // Reset with a non-zero input present
    cycle(1'b1, 4'h5, 1'b0);
    cycle(1'b1, 4'h5, 1'b0);

    // Legal count through 20 codes, wrapping once
    n_wrap = 0;
    for (int i = 0; i < 20; i++) begin
      cur_b = i % 16;
      cycle(1'b0, to_gray(cur_b), 1'b0);
      if (wrap_pulse) n_wrap++;
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, to_gray(cur_b), 1'b0);
      if (wrap_pulse) n_wrap++;
    end
    chk("wrap_once", 32'(n_wrap), 32'd1);
    chk("legal_locked", 32'(locked), 32'd1);
    chk("legal_errs", 32'(err_count), 32'd0);

    // Hold at 0x6 while locked
    cycle(1'b0, 4'h6, 1'b0);
    cur_b = 4;
    hold(9);
    chk("hold_bin", 32'(bin_out), 32'd4);
    chk("hold_locked", 32'(locked), 32'd1);

    // Walk to 0x3, then jump to 0x6
    walk(14);
    hold(4);
    chk("pre_jump_gray", 32'(to_gray(cur_b)), 32'h3);
    cycle(1'b0, 4'h6, 1'b0);
    cur_b = 4;
    hold(3);
    chk("jump_errs", 32'(err_count), 32'd1);
    chk("jump_unlock", 32'(locked), 32'd0);
    walk(4);
    hold(3);
    chk("relock", 32'(locked), 32'd1);

    // Reverse step 0x3 -> 0x1
    walk(10);
    hold(3);
    cycle(1'b0, 4'h1, 1'b0);
    cur_b = 1;
    n_inc = 0; n_err = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'h1, 1'b0);
      if (inc_pulse) n_inc++;
      if (step_err) n_err++;
    end
    chk("rev_no_inc", 32'(n_inc), 32'd0);
    chk("rev_one_err", 32'(n_err), 32'd1);
    cycle(1'b0, 4'h1, 1'b1);

    // Three illegal steps force FAULT; outputs then freeze
    jump2(); hold(2);
    jump2(); hold(2);
    jump2(); hold(3);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_errs", 32'(err_count), 32'd3);
    chk("fault_bin", 32'(bin_out), 32'(cur_b));
    walk(5);
    hold(2);
    chk("fault_frozen", 32'(bin_out), 32'(inv_tab[to_gray(cur_b - 5)]));
    cycle(1'b0, to_gray(cur_b), 1'b1);
    chk("clr_errs", 32'(err_count), 32'd0);
    chk("clr_fault", 32'(fault), 32'd0);
    hold(3);
    walk(6);
    hold(3);
    chk("recover_lock", 32'(locked), 32'd1);

    // clr_err on the same edge as the third illegal step
    jump2(); hold(3);
    jump2(); hold(3);
    cur_b = (cur_b + 2) % 16;
    cycle(1'b0, to_gray(cur_b), 1'b0);
    cycle(1'b0, to_gray(cur_b), 1'b0);
    cycle(1'b0, to_gray(cur_b), 1'b1);
    chk("coinc_step", 32'(step_err), 32'd1);
    chk("coinc_errs", 32'(err_count), 32'd0);
    chk("coinc_nofault", 32'(fault), 32'd0);
    hold(2);

    // Random mix checked cycle by cycle against the model
    for (int i = 0; i < 1500; i++) begin
      int op;
      logic r, c;
      r  = ($urandom_range(0, 249) == 0);
      c  = ($urandom_range(0, 39) == 0);
      op = $urandom_range(0, 9);
      if (op <= 5)      cur_b = (cur_b + 1) % 16;
      else if (op == 8) cur_b = (cur_b + 15) % 16;
      else if (op == 9) cur_b = $urandom_range(0, 15);
      cycle(r, to_gray(cur_b), c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
